mse_accum: RTL and testbench

// - Downstream of the 3-tap FIR: consumes the approximate-adder FIR output stream alongside the

---
 rtl/mse_accum_if.sv | 45 ++++
 rtl/mse_accum.sv | 186 ++++++++++++++++++
 tb/tb_mse_accum.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/mse_accum_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mse_accum_if                                                 |
// | Description : Bundle of the handshake and result signals of mse_accum.     |
// |               master : frame controller / sample source / result consumer  |
// |               slave  : the error accumulator itself                        |
// |   start       m->s  1-cycle frame start request                            |
// |   in_valid    m->s  y_approx / y_exact valid this cycle                    |
// |   y_approx    m->s  signed approximate FIR sample                          |
// |   y_exact     m->s  signed exact FIR sample                                |
// |   res_ack     m->s  consumer accepts results                               |
// |   busy        s->m  frame in progress (skip, accumulate, drain)            |
// |   res_valid   s->m  results stable, held until res_ack                     |
// |   sse / mse   s->m  sum / mean of squared errors                           |
// |   max_abs_err s->m  peak absolute error                                    |
// |   ovf         s->m  sum of squares saturated during the frame              |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
interface mse_accum_if #(
   parameter int DATA_W = 16,
   parameter int ACC_W  = 48
);
   logic                     start;
   logic                     in_valid;
   logic signed [DATA_W-1:0] y_approx;
   logic signed [DATA_W-1:0] y_exact;
   logic                     res_ack;
   logic                     busy;
   logic                     res_valid;
   logic        [ACC_W-1:0]  sse;
   logic        [ACC_W-1:0]  mse;
   logic        [DATA_W:0]   max_abs_err;
   logic                     ovf;

   modport master (
      output start, in_valid, y_approx, y_exact, res_ack,
      input  busy, res_valid, sse, mse, max_abs_err, ovf
   );

   modport slave (
      input  start, in_valid, y_approx, y_exact, res_ack,
      output busy, res_valid, sse, mse, max_abs_err, ovf
   );
endinterface
`default_nettype wire

// File: rtl/mse_accum.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mse_accum                                                    |
// | Description : Per-frame error statistics between an approximate and an    |
// |               exact FIR output stream: sum of squared errors, mean squared |
// |               error and peak absolute error, with saturation flag.         |
// | Ports       : clk  rising-edge clock                                       |
// |               rst  asynchronous reset, active-high                         |
// |               bus  mse_accum_if.slave (samples in, handshake, results out) |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module mse_accum #(
   parameter int DATA_W     = 16,
   parameter int LOG2_FRAME = 10,
   parameter int SKIP_N     = 2,
   parameter int ACC_W      = 48
) (
   input  logic          clk,
   input  logic          rst,
   mse_accum_if.slave    bus
);

   localparam int c_sq_w  = 2*DATA_W + 2;
   // One bit wider than both addends so the carry out flags saturation.
   localparam int c_sum_w = ((ACC_W > c_sq_w) ? ACC_W : c_sq_w) + 1;
   localparam int c_cnt_w = LOG2_FRAME + 1;
   localparam logic [c_cnt_w-1:0] c_frame_last = c_cnt_w'((1 << LOG2_FRAME) - 1);
   localparam logic [c_cnt_w-1:0] c_skip_last  = c_cnt_w'((SKIP_N > 0) ? SKIP_N - 1 : 0);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SKIP  = 3'd1,
      ST_ACCUM = 3'd2,
      ST_DRAIN = 3'd3,
      ST_DONE  = 3'd4
   } state_t;

   state_t                     r_state;
   state_t                     w_state_nxt;
   logic        [c_cnt_w-1:0]  r_cnt;
   logic                       r_s1_vld;
   logic signed [DATA_W:0]     r_s1_diff;
   logic        [DATA_W:0]     r_s1_abs;
   logic                       r_s2_vld;
   logic        [c_sq_w-1:0]   r_sq;
   logic        [DATA_W:0]     r_max;
   logic        [ACC_W-1:0]    r_acc;
   logic                       r_ovf;
   logic        [ACC_W-1:0]    r_sse;
   logic        [ACC_W-1:0]    r_mse;
   logic        [DATA_W:0]     r_max_out;
   logic                       r_ovf_out;

   logic                       w_begin;
   logic                       w_skip;
   logic                       w_take;
   logic                       w_done_entry;
   logic signed [DATA_W:0]     w_diff;
   logic        [DATA_W:0]     w_abs;
   logic signed [c_sq_w-1:0]   w_dx;
   logic signed [c_sq_w-1:0]   w_sq;
   logic        [c_sum_w-1:0]  w_sum;
   logic                       w_sat;

   assign w_begin      = bus.start && (r_state == ST_IDLE);
   assign w_skip       = bus.in_valid && (r_state == ST_SKIP);
   assign w_take       = bus.in_valid && (r_state == ST_ACCUM);
   assign w_done_entry = (r_state == ST_DRAIN) && (w_state_nxt == ST_DONE);

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ST_IDLE;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (bus.start)
                      w_state_nxt = (SKIP_N == 0) ? ST_ACCUM : ST_SKIP;
         ST_SKIP:  if (bus.in_valid && (r_cnt == c_skip_last))
                      w_state_nxt = ST_ACCUM;
         ST_ACCUM: if (bus.in_valid && (r_cnt == c_frame_last))
                      w_state_nxt = ST_DRAIN;
         // Both pipeline stages empty means the final square is in r_acc.
         ST_DRAIN: if (!r_s1_vld && !r_s2_vld)
                      w_state_nxt = ST_DONE;
         ST_DONE:  if (bus.res_ack)
                      w_state_nxt = ST_IDLE;
         default:  w_state_nxt = ST_IDLE;
      endcase
   end

   // Shared sample counter: counts discarded fill samples in SKIP, then
   // restarts at zero for the frame proper.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)          r_cnt <= '0;
      else if (w_begin) r_cnt <= '0;
      else if (w_skip)  r_cnt <= (r_cnt == c_skip_last) ? '0 : r_cnt + 1'b1;
      else if (w_take)  r_cnt <= r_cnt + 1'b1;
   end

   // ---------------------------------------------------------------- S1
   // Extending before subtracting keeps the full range of the difference.
   assign w_diff = {bus.y_approx[DATA_W-1], bus.y_approx} - {bus.y_exact[DATA_W-1], bus.y_exact};
   assign w_abs  = w_diff[DATA_W] ? (~w_diff + 1'b1) : w_diff;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_vld  <= 1'b0;
         r_s1_diff <= '0;
         r_s1_abs  <= '0;
      end else begin
         r_s1_vld <= w_take;
         if (w_take) begin
            r_s1_diff <= w_diff;
            r_s1_abs  <= w_abs;
         end
      end
   end

   // ---------------------------------------------------------------- S2
   assign w_dx = c_sq_w'(r_s1_diff);
   assign w_sq = w_dx * w_dx;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s2_vld <= 1'b0;
         r_sq     <= '0;
         r_max    <= '0;
      end else begin
         r_s2_vld <= r_s1_vld;
         if (r_s1_vld) r_sq <= w_sq;
         if (w_begin)
            r_max <= '0;
         else if (r_s1_vld && (r_s1_abs > r_max))
            r_max <= r_s1_abs;
      end
   end

   // ---------------------------------------------------------------- S3
   assign w_sum = c_sum_w'(r_acc) + c_sum_w'(r_sq);
   assign w_sat = |w_sum[c_sum_w-1:ACC_W];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_acc <= '0;
         r_ovf <= 1'b0;
      end else if (w_begin) begin
         r_acc <= '0;
         r_ovf <= 1'b0;
      end else if (r_s2_vld) begin
         if (w_sat) begin
            r_acc <= '1;
            r_ovf <= 1'b1;
         end else begin
            r_acc <= w_sum[ACC_W-1:0];
         end
      end
   end

   // ---------------------------------------------------------------- results
   // Captured once on DONE entry and held until the next frame completes.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sse     <= '0;
         r_mse     <= '0;
         r_max_out <= '0;
         r_ovf_out <= 1'b0;
      end else if (w_done_entry) begin
         r_sse     <= r_acc;
         r_mse     <= r_acc >> LOG2_FRAME;
         r_max_out <= r_max;
         r_ovf_out <= r_ovf;
      end
   end

   assign bus.busy        = (r_state == ST_SKIP) || (r_state == ST_ACCUM) || (r_state == ST_DRAIN);
   assign bus.res_valid   = (r_state == ST_DONE);
   assign bus.sse         = r_sse;
   assign bus.mse         = r_mse;
   assign bus.max_abs_err = r_max_out;
   assign bus.ovf         = r_ovf_out;

endmodule
`default_nettype wire

// File: tb/tb_mse_accum.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mse_accum                                                 |
// | Description : Directed self-checking bench for mse_accum. Three instances  |
// |               share one stimulus stream: A defaults, B with SKIP_N=0,      |
// |               C with ACC_W=34.                                             |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_mse_accum;

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic               start = 1'b0;
   logic               in_valid = 1'b0;
   logic signed [15:0] y_approx = '0;
   logic signed [15:0] y_exact = '0;
   logic               res_ack = 1'b0;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   mse_accum_if #(.DATA_W(16), .ACC_W(48)) if_a ();
   mse_accum_if #(.DATA_W(16), .ACC_W(48)) if_b ();
   mse_accum_if #(.DATA_W(16), .ACC_W(34)) if_c ();

   assign if_a.start = start;   assign if_b.start = start;   assign if_c.start = start;
   assign if_a.in_valid = in_valid; assign if_b.in_valid = in_valid; assign if_c.in_valid = in_valid;
   assign if_a.y_approx = y_approx; assign if_b.y_approx = y_approx; assign if_c.y_approx = y_approx;
   assign if_a.y_exact = y_exact;   assign if_b.y_exact = y_exact;   assign if_c.y_exact = y_exact;
   assign if_a.res_ack = res_ack;   assign if_b.res_ack = res_ack;   assign if_c.res_ack = res_ack;

   mse_accum #(.DATA_W(16), .LOG2_FRAME(10), .SKIP_N(2), .ACC_W(48))
      u_a (.clk(clk), .rst(rst), .bus(if_a));
   mse_accum #(.DATA_W(16), .LOG2_FRAME(10), .SKIP_N(0), .ACC_W(48))
      u_b (.clk(clk), .rst(rst), .bus(if_b));
   mse_accum #(.DATA_W(16), .LOG2_FRAME(10), .SKIP_N(2), .ACC_W(34))
      u_c (.clk(clk), .rst(rst), .bus(if_c));

   // Sample pair generator for the directed patterns.
   task automatic gen(input int mode, input int i,
                      output logic signed [15:0] ya, output logic signed [15:0] ye);
      case (mode)
         0: begin ye = 16'($urandom); ya = ye; end
         1: begin ye = 16'($urandom_range(0, 65534)) ^ 16'h8000; ya = ye + 16'sd1; end
         2: begin ya = 16'sh7FFF; ye = 16'sh8000; end
         3: begin ye = 16'(i); ya = (i < 2) ? 16'(i + 100) : 16'(i); end
         default: begin ye = 16'(i - 500); ya = 16'(i - 497); end
      endcase
   endtask

   // Start pulse followed by n valid samples; optional idle gaps, optionally
   // carrying start pulses that the busy DUT must ignore.
   task automatic send_stream(input int mode, input int n, input bit gaps, input bit start_in_gaps);
      logic signed [15:0] ya, ye;
      start = 1'b1; @(posedge clk); #1; start = 1'b0;
      for (int i = 0; i < n; i++) begin
         gen(mode, i, ya, ye);
         y_approx = ya; y_exact = ye; in_valid = 1'b1;
         @(posedge clk); #1;
         if (gaps && i != n - 1) begin
            in_valid = 1'b0; y_approx = 16'($urandom); start = start_in_gaps;
            @(posedge clk); #1;
            start = 1'b0;
         end
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_res();
      int k = 0;
      while (!if_a.res_valid && k < 20) begin @(posedge clk); #1; k++; end
      n_checks++;
      if (if_a.res_valid !== 1'b1) begin
         n_fail++; $display("FAIL res_valid_timeout: got %b expected 1", if_a.res_valid);
      end
   endtask

   task automatic ack_results();
      res_ack = 1'b1; @(posedge clk); #1; res_ack = 1'b0;
      n_checks++;
      if (if_a.res_valid !== 1'b0) begin
         n_fail++; $display("FAIL res_valid_after_ack: got %b expected 0", if_a.res_valid);
      end
   endtask

   task automatic test_reset();
      #12;
      n_checks += 4;
      if (if_a.sse !== 48'd0)         begin n_fail++; $display("FAIL rst_sse: got %0d expected 0", if_a.sse); end
      if (if_a.busy !== 1'b0)         begin n_fail++; $display("FAIL rst_busy: got %b expected 0", if_a.busy); end
      if (if_a.res_valid !== 1'b0)    begin n_fail++; $display("FAIL rst_res_valid: got %b expected 0", if_a.res_valid); end
      if (if_c.max_abs_err !== 17'd0) begin n_fail++; $display("FAIL rst_max: got %0d expected 0", if_c.max_abs_err); end
      #5 rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_zero_error();
      send_stream(0, 1026, 1'b0, 1'b0);
      wait_res();
      n_checks += 4;
      if (if_a.sse !== 48'd0)         begin n_fail++; $display("FAIL zero_sse: got %0d expected 0", if_a.sse); end
      if (if_a.mse !== 48'd0)         begin n_fail++; $display("FAIL zero_mse: got %0d expected 0", if_a.mse); end
      if (if_a.max_abs_err !== 17'd0) begin n_fail++; $display("FAIL zero_max: got %0d expected 0", if_a.max_abs_err); end
      if (if_a.ovf !== 1'b0)          begin n_fail++; $display("FAIL zero_ovf: got %b expected 0", if_a.ovf); end
      ack_results();
   endtask

   // Diff of +1 with gapped input and ignored start pulses; also checks the
   // 3-cycle result latency. Results are left pending for the handshake test.
   task automatic test_unit_error();
      send_stream(1, 1026, 1'b1, 1'b1);
      for (int k = 1; k <= 3; k++) begin
         @(posedge clk); #1;
         n_checks++;
         if (if_a.res_valid !== (k == 3)) begin
            n_fail++; $display("FAIL latency_cycle%0d: got %b expected %b", k, if_a.res_valid, (k == 3));
         end
      end
      n_checks += 4;
      if (if_a.sse !== 48'd1024)      begin n_fail++; $display("FAIL unit_sse: got %0d expected 1024", if_a.sse); end
      if (if_a.mse !== 48'd1)         begin n_fail++; $display("FAIL unit_mse: got %0d expected 1", if_a.mse); end
      if (if_a.max_abs_err !== 17'd1) begin n_fail++; $display("FAIL unit_max: got %0d expected 1", if_a.max_abs_err); end
      if (if_b.sse !== 48'd1024)      begin n_fail++; $display("FAIL unit_sse_b: got %0d expected 1024", if_b.sse); end
   endtask

   task automatic test_handshake();
      for (int i = 0; i < 20; i++) begin
         in_valid = i[0]; y_approx = 16'($urandom); y_exact = 16'($urandom);
         start = (i % 5 == 0);
         @(posedge clk); #1;
         n_checks += 2;
         if (if_a.res_valid !== 1'b1) begin n_fail++; $display("FAIL hold_res_valid%0d: got %b expected 1", i, if_a.res_valid); end
         if (if_a.sse !== 48'd1024)   begin n_fail++; $display("FAIL hold_sse%0d: got %0d expected 1024", i, if_a.sse); end
      end
      in_valid = 1'b0; start = 1'b0;
      ack_results();
      @(posedge clk); #1;
      n_checks += 2;
      if (if_a.sse !== 48'd1024) begin n_fail++; $display("FAIL idle_hold_sse: got %0d expected 1024", if_a.sse); end
      if (if_a.busy !== 1'b0)    begin n_fail++; $display("FAIL idle_busy: got %b expected 0", if_a.busy); end
   endtask

   task automatic test_full_scale();
      send_stream(2, 1026, 1'b0, 1'b0);
      wait_res();
      n_checks += 8;
      if (if_a.sse !== 48'd4397912294400) begin n_fail++; $display("FAIL fs_sse: got %0d expected 4397912294400", if_a.sse); end
      if (if_a.mse !== 48'd4294836225)    begin n_fail++; $display("FAIL fs_mse: got %0d expected 4294836225", if_a.mse); end
      if (if_a.max_abs_err !== 17'd65535) begin n_fail++; $display("FAIL fs_max: got %0d expected 65535", if_a.max_abs_err); end
      if (if_a.ovf !== 1'b0)              begin n_fail++; $display("FAIL fs_ovf: got %b expected 0", if_a.ovf); end
      if (if_c.sse !== 34'h3_FFFF_FFFF)   begin n_fail++; $display("FAIL sat_sse: got %0d expected 17179869183", if_c.sse); end
      if (if_c.mse !== 34'd16777215)      begin n_fail++; $display("FAIL sat_mse: got %0d expected 16777215", if_c.mse); end
      if (if_c.ovf !== 1'b1)              begin n_fail++; $display("FAIL sat_ovf: got %b expected 1", if_c.ovf); end
      if (if_c.max_abs_err !== 17'd65535) begin n_fail++; $display("FAIL sat_max: got %0d expected 65535", if_c.max_abs_err); end
      ack_results();
   endtask

   task automatic test_reset_mid_frame();
      logic signed [15:0] ya, ye;
      start = 1'b1; @(posedge clk); #1; start = 1'b0;
      for (int i = 0; i < 100; i++) begin
         gen(4, i, ya, ye);
         y_approx = ya; y_exact = ye; in_valid = 1'b1;
         @(posedge clk); #1;
      end
      #3 rst = 1'b1;
      #1;
      n_checks += 5;
      if (if_a.sse !== 48'd0)         begin n_fail++; $display("FAIL mid_rst_sse: got %0d expected 0", if_a.sse); end
      if (if_a.mse !== 48'd0)         begin n_fail++; $display("FAIL mid_rst_mse: got %0d expected 0", if_a.mse); end
      if (if_a.busy !== 1'b0)         begin n_fail++; $display("FAIL mid_rst_busy: got %b expected 0", if_a.busy); end
      if (if_c.ovf !== 1'b0)          begin n_fail++; $display("FAIL mid_rst_ovf: got %b expected 0", if_c.ovf); end
      if (if_c.max_abs_err !== 17'd0) begin n_fail++; $display("FAIL mid_rst_max: got %0d expected 0", if_c.max_abs_err); end
      in_valid = 1'b0;
      #1 rst = 1'b0;
      @(posedge clk); #1;
      send_stream(4, 1026, 1'b0, 1'b0);
      wait_res();
      n_checks += 4;
      if (if_a.sse !== 48'd9216)      begin n_fail++; $display("FAIL post_rst_sse: got %0d expected 9216", if_a.sse); end
      if (if_a.mse !== 48'd9)         begin n_fail++; $display("FAIL post_rst_mse: got %0d expected 9", if_a.mse); end
      if (if_a.max_abs_err !== 17'd3) begin n_fail++; $display("FAIL post_rst_max: got %0d expected 3", if_a.max_abs_err); end
      if (if_c.ovf !== 1'b0)          begin n_fail++; $display("FAIL post_rst_ovf: got %b expected 0", if_c.ovf); end
      ack_results();
   endtask

   task automatic test_skip();
      send_stream(3, 1026, 1'b0, 1'b0);
      wait_res();
      n_checks += 5;
      if (if_a.sse !== 48'd0)           begin n_fail++; $display("FAIL skip2_sse: got %0d expected 0", if_a.sse); end
      if (if_a.max_abs_err !== 17'd0)   begin n_fail++; $display("FAIL skip2_max: got %0d expected 0", if_a.max_abs_err); end
      if (if_b.sse !== 48'd20000)       begin n_fail++; $display("FAIL skip0_sse: got %0d expected 20000", if_b.sse); end
      if (if_b.mse !== 48'd19)          begin n_fail++; $display("FAIL skip0_mse: got %0d expected 19", if_b.mse); end
      if (if_b.max_abs_err !== 17'd100) begin n_fail++; $display("FAIL skip0_max: got %0d expected 100", if_b.max_abs_err); end
      ack_results();
   endtask

   // start coincident with res_ack is dropped; then a frame follows at once.
   task automatic test_back_to_back();
      send_stream(1, 1026, 1'b0, 1'b0);
      wait_res();
      res_ack = 1'b1; start = 1'b1;
      @(posedge clk); #1;
      res_ack = 1'b0; start = 1'b0;
      @(posedge clk); #1;
      n_checks += 3;
      if (if_a.res_valid !== 1'b0) begin n_fail++; $display("FAIL b2b_res_valid: got %b expected 0", if_a.res_valid); end
      if (if_a.busy !== 1'b0)      begin n_fail++; $display("FAIL b2b_start_dropped: got %b expected 0", if_a.busy); end
      if (if_a.sse !== 48'd1024)   begin n_fail++; $display("FAIL b2b_hold_sse: got %0d expected 1024", if_a.sse); end
      send_stream(0, 1026, 1'b0, 1'b0);
      wait_res();
      n_checks += 2;
      if (if_a.sse !== 48'd0) begin n_fail++; $display("FAIL b2b_next_sse: got %0d expected 0", if_a.sse); end
      if (if_b.sse !== 48'd0) begin n_fail++; $display("FAIL b2b_next_sse_b: got %0d expected 0", if_b.sse); end
      ack_results();
   endtask

   initial begin
      test_reset();
      test_zero_error();
      test_unit_error();
      test_handshake();
      test_full_scale();
      test_reset_mid_frame();
      test_skip();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire
